memtest_disp_sched: RTL and testbench
=====================================

Name: memtest_disp_sched

Overview:
- Sequences all status values shown by the 720x400@70 status display: pass/error counters, elapsed time, frequency setting, edit cursor mark and background colour.
- Holds a run/idle/error state machine and BCD counters.
- Publishes a coherent snapshot to the display only on the rising edge of vertical sync, so a frame never shows mixed old/new values.
- Sits between the memory tester core and the display generator, in the same 14 MHz clock domain.

Parameters:
TICK_DIV, 14000000, clk cycles per elapsed-time second
BLINK_FRAMES, 35, frames per blink half-period
FREQ_DEFAULT, 16'h0100, reset BCD frequency setting

Ports:
clk  in  1  system clock, 14 MHz
reset_n  in  1  asynchronous active-low reset
vs_in  in  1  vertical sync from display generator, active high
test_run  in  1  level: tester running
pass_strobe  in  1  one-cycle pulse: one pass completed
err_strobe  in  1  one-cycle pulse: one error detected
err_addr  in  32  failing address, valid with err_strobe
key_sel  in  1  one-cycle pulse: move edit cursor
key_up  in  1  one-cycle pulse: increment digit under cursor
freq_set  out  16  live BCD frequency setting to clock generator
rez1  out  32  display: pass count, 8 BCD digits
rez2  out  32  display: error count, 8 BCD digits
rez3  out  2  display: status code
elapsed  out  16  display: MMSS in BCD
freq  out  16  display: frequency snapshot
mark  out  8  display: digit highlight, bit7 = leftmost digit of {elapsed,freq}
bg  out  6  display background colour {g[1:0],r[1:0],b[1:0]}

Behaviour:
- Reset values:
  - freq_set and freq = FREQ_DEFAULT.
  - rez1, rez2, rez3, elapsed and mark = 0.
  - bg = 6'b000010 (IDLE blue).
  - All internal counters = 0; FSM = IDLE; cursor = 0.
- FSM, with state code driving rez3:
  - IDLE (0): on test_run 0->1 go to RUN, clearing pass count, error count, elapsed and the divider.
  - RUN (1): on err_strobe go to ERR; on test_run=0 go to IDLE.
  - ERR (2): on test_run=0 go to IDLE.
  - Counters are retained on entry to IDLE.
  - rez3=3 overrides the state code while any counter is saturated.
- Pass and error counters:
  - 8-digit BCD, +1 per strobe, saturating at 99999999.
  - pass_strobe and err_strobe in the same cycle increment both counters.
  - Strobes are ignored in IDLE.
- Elapsed time:
  - Divider counts 0..TICK_DIV-1 in RUN/ERR only; on wrap, elapsed +1s.
  - SS wraps 59->00 with a carry into MM.
  - Elapsed saturates at 9959.
- Edit path (IDLE only; keys ignored in RUN/ERR):
  - key_sel: cursor 0->1->2->3->0.
  - key_up: digit freq_set[15-4*cursor -: 4] increments, wrapping 9->0 with no carry.
  - key_sel and key_up in the same cycle: only the increment is applied, at the old cursor.
  - freq_set updates the cycle after the key pulse.
- Blink:
  - Frame counter counts vs_in rising edges 0..BLINK_FRAMES-1.
  - On wrap, blink phase toggles.
  - Phase resets to 1 (on) at every FSM transition.
- Snapshot:
  - vs_in is registered once; a rising edge (previous 0, current 1) loads all display outputs on the next clk edge.
  - Total latency from vs_in high to updated outputs = 2 clk.
  - Values loaded are the live internal values in the cycle of edge detection.
  - A strobe in that same cycle appears in the next frame.
- Snapshot contents:
  - mark: IDLE with phase on -> one-hot bit (3-cursor); otherwise 0.
  - bg: IDLE 6'b000010; RUN 6'b100000; ERR 6'b001000 when phase on, 6'b000000 when phase off.
- Reset asserted mid-operation returns everything to the reset values immediately; no snapshot occurs until the first vs_in edge after reset release.

Optional Feature:
- MEMTEST_ERRADDR_EN.
- Defined: rez2 shows the err_addr captured at the most recent err_strobe (32'h0 until the first error); the error counter still runs and still drives saturation in rez3.
- Undefined: rez2 = error count, and err_addr is unused.

Decomposition:
- Package memtest_disp_pkg:
  - state enum (IDLE/RUN/ERR);
  - colour constants (COL_IDLE, COL_RUN, COL_ERR, COL_OFF);
  - 4-bit BCD digit type;
  - BCD max constants.
- Sub-module bcd_counter: parameters DIGITS and MAXVAL; ports clear, inc, value, sat. Instantiated for the pass count, the error count and the elapsed time; the elapsed instance uses a mod-60 low pair.

Test Plan:
- Reset, then 3 vs_in pulses -> freq=16'h0100, bg=6'b000010, rez3=0; mark toggles between 8'h08 and 0 every 35 frames.
- IDLE: key_sel x2, key_up x12 -> freq_set=16'h0120 one clk after the last pulse (digit 2: 0->2 after wrap); freq updates only 2 clk after the next vs_in rise.
- test_run=1, 5 pass_strobe, then vs_in edge -> rez1=32'h00000005, rez3=1, bg=6'b100000; TICK_DIV set to 4 with 240 ticks -> elapsed=16'h0400.
- err_strobe and pass_strobe in the same cycle -> rez1 and rez2 both +1, rez3=2; bg alternates 6'b001000/0; keys ignored.
- Preload the pass count to 99999999, then pass_strobe -> stays 32'h99999999, rez3=3.
- reset_n low mid-RUN, then released -> all outputs at reset values, FSM IDLE; a strobe in the first cycle after release is ignored.

Source files
------------

// File: rtl/memtest_disp_pkg.sv
// Shared types and constants for the memory-tester status display scheduler.
package memtest_disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Background colours, packed as {g[1:0], r[1:0], b[1:0]}
   localparam logic [5:0] COL_IDLE = 6'b000010;
   localparam logic [5:0] COL_RUN  = 6'b100000;
   localparam logic [5:0] COL_ERR  = 6'b001000;
   localparam logic [5:0] COL_OFF  = 6'b000000;

   localparam logic [31:0] BCD8_MAX = 32'h9999_9999;
   localparam logic [15:0] MMSS_MAX = 16'h9959;

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD counter; MOD60_LO makes the low digit pair count 00..59.
module bcd_counter
   import memtest_disp_pkg::*;
#(
   parameter int unsigned          DIGITS   = 8,
   parameter logic [4*DIGITS-1:0]  MAXVAL   = '1,
   parameter bit                   MOD60_LO = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                inc,
   output logic [4*DIGITS-1:0] value,
   output logic                sat
);

   logic [4*DIGITS-1:0] cnt_q;
   logic [4*DIGITS-1:0] cnt_nxt;

   always_comb begin
      logic       carry;
      bcd_digit_t lim;
      bcd_digit_t d;
      cnt_nxt = cnt_q;
      carry   = 1'b1;
      lim     = 4'd9;
      d       = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         d   = cnt_q[4*i +: 4];
         lim = (MOD60_LO && i == 1) ? 4'd5 : 4'd9;
         if (carry) begin
            if (d == lim) begin
               cnt_nxt[4*i +: 4] = '0;
            end else begin
               cnt_nxt[4*i +: 4] = d + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   assign sat   = (cnt_q == MAXVAL);
   assign value = cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         cnt_q <= '0;
      else if (clear)       cnt_q <= '0;
      else if (inc && !sat) cnt_q <= cnt_nxt;
   end

endmodule

// File: rtl/memtest_disp_sched.sv
// Status sequencer for the 720x400@70 display; snapshots all fields on vsync rise.
// Optional MEMTEST_ERRADDR_EN: rez2 shows the last failing address instead of the error count.
module memtest_disp_sched
   import memtest_disp_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 14000000,
   parameter int unsigned BLINK_FRAMES = 35,
   parameter logic [15:0] FREQ_DEFAULT = 16'h0100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        vs_in,
   input  logic        test_run,
   input  logic        pass_strobe,
   input  logic        err_strobe,
   input  logic [31:0] err_addr,
   input  logic        key_sel,
   input  logic        key_up,
   output logic [15:0] freq_set,
   output logic [31:0] rez1,
   output logic [31:0] rez2,
   output logic [1:0]  rez3,
   output logic [15:0] elapsed,
   output logic [15:0] freq,
   output logic [7:0]  mark,
   output logic [5:0]  bg
);

   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   state_t           state_q, state_nxt;
   logic             test_run_q, vs_q1, vs_q2, vs_rise, phase_q;
   logic             active, idle, run_start, sec_tick;
   logic [DIV_W-1:0] div_q;
   logic [FRM_W-1:0] frame_q;
   logic [1:0]       cursor_q, dig_sel;
   bcd_digit_t       dig_cur;
   logic [15:0]      freq_nxt, elapsed_cnt;
   logic [31:0]      pass_cnt, err_cnt, rez2_nxt;
   logic             pass_sat, err_sat, el_sat;
   logic [7:0]       mark_nxt;
   logic [5:0]       bg_nxt;

   assign idle      = (state_q == IDLE);
   assign active    = !idle;
   assign run_start = idle && test_run && !test_run_q;
   assign sec_tick  = active && (div_q == DIV_LAST);
   assign vs_rise   = vs_q1 && !vs_q2;

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (run_start) state_nxt = RUN;
         RUN:     if (!test_run) state_nxt = IDLE;
                  else if (err_strobe) state_nxt = ERR;
         ERR:     if (!test_run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   bcd_counter #(.DIGITS(8), .MAXVAL(BCD8_MAX), .MOD60_LO(1'b0)) u_pass (
      .clk(clk), .reset_n(reset_n), .clear(run_start), .inc(active && pass_strobe),
      .value(pass_cnt), .sat(pass_sat));

   bcd_counter #(.DIGITS(8), .MAXVAL(BCD8_MAX), .MOD60_LO(1'b0)) u_err (
      .clk(clk), .reset_n(reset_n), .clear(run_start), .inc(active && err_strobe),
      .value(err_cnt), .sat(err_sat));

   bcd_counter #(.DIGITS(4), .MAXVAL(MMSS_MAX), .MOD60_LO(1'b1)) u_elapsed (
      .clk(clk), .reset_n(reset_n), .clear(run_start), .inc(sec_tick),
      .value(elapsed_cnt), .sat(el_sat));

`ifdef MEMTEST_ERRADDR_EN
   logic [31:0] err_addr_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  err_addr_q <= '0;
      else if (active && err_strobe) err_addr_q <= err_addr;
   end
   assign rez2_nxt = err_addr_q;
`else
   logic unused_err_addr;
   assign unused_err_addr = ^err_addr;
   assign rez2_nxt        = err_cnt;
`endif

   // Cursor 0 selects the leftmost freq digit, i.e. nibble index 3
   assign dig_sel = 2'd3 - cursor_q;
   assign dig_cur = freq_set[{dig_sel, 2'b00} +: 4];

   always_comb begin
      freq_nxt = freq_set;
      freq_nxt[{dig_sel, 2'b00} +: 4] = (dig_cur == 4'd9) ? 4'd0 : dig_cur + 4'd1;
   end

   always_comb begin
      mark_nxt = '0;
      if (idle && phase_q) mark_nxt[{1'b0, dig_sel}] = 1'b1;
      case (state_q)
         RUN:     bg_nxt = COL_RUN;
         ERR:     bg_nxt = phase_q ? COL_ERR : COL_OFF;
         default: bg_nxt = COL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         test_run_q <= 1'b0;
         vs_q1      <= 1'b0;
         vs_q2      <= 1'b0;
         div_q      <= '0;
         frame_q    <= '0;
         phase_q    <= 1'b1;
         cursor_q   <= '0;
         freq_set   <= FREQ_DEFAULT;
      end else begin
         state_q    <= state_nxt;
         test_run_q <= test_run;
         vs_q1      <= vs_in;
         vs_q2      <= vs_q1;
         if (run_start)   div_q <= '0;
         else if (active) div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
         if (vs_rise)     frame_q <= (frame_q == FRM_LAST) ? '0 : frame_q + FRM_W'(1);
         if (state_nxt != state_q)           phase_q <= 1'b1;
         else if (vs_rise && frame_q == FRM_LAST) phase_q <= !phase_q;
         // key_up wins over key_sel so a simultaneous press edits the old cursor position
         if (idle && key_up)       freq_set <= freq_nxt;
         else if (idle && key_sel) cursor_q <= cursor_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rez1    <= '0;
         rez2    <= '0;
         rez3    <= '0;
         elapsed <= '0;
         freq    <= FREQ_DEFAULT;
         mark    <= '0;
         bg      <= COL_IDLE;
      end else if (vs_rise) begin
         rez1    <= pass_cnt;
         rez2    <= rez2_nxt;
         rez3    <= (pass_sat || err_sat || el_sat) ? 2'd3 : state_q;
         elapsed <= elapsed_cnt;
         freq    <= freq_set;
         mark    <= mark_nxt;
         bg      <= bg_nxt;
      end
   end

endmodule

// File: tb/tb_memtest_disp_sched.sv
// Directed bench for memtest_disp_sched: vector table plus multi-cycle corner sequences.
module tb_memtest_disp_sched;

   typedef struct {
      logic [5:0]  in;   // {vs, run, pass, err, sel, up}
      bit          chk;
      logic [15:0] fs, fq;
      logic [31:0] r1, r2;
      logic [1:0]  r3;
      logic [5:0]  bg;
      logic [7:0]  mk;
   } vec_t;

   localparam logic [5:0] NO = 6'b000000, VS = 6'b100000, RN = 6'b010000, PS = 6'b001000;
   localparam logic [5:0] ES = 6'b000100, KS = 6'b000010, KU = 6'b000001;
`ifdef MEMTEST_ERRADDR_EN
   localparam logic [31:0] ERR1 = 32'hDEADBEEF;
   localparam logic [31:0] ERR0 = 32'hDEADBEEF;
`else
   localparam logic [31:0] ERR1 = 32'h1;
   localparam logic [31:0] ERR0 = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, vs_in, test_run, pass_strobe, err_strobe, key_sel, key_up;
   logic [31:0] err_addr;
   logic [15:0] freq_set, elapsed, freq;
   logic [31:0] rez1, rez2;
   logic [1:0]  rez3;
   logic [7:0]  mark;
   logic [5:0]  bg;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   memtest_disp_sched #(.TICK_DIV(4), .BLINK_FRAMES(35), .FREQ_DEFAULT(16'h0100)) dut (
      .clk(clk), .reset_n(reset_n), .vs_in(vs_in), .test_run(test_run),
      .pass_strobe(pass_strobe), .err_strobe(err_strobe), .err_addr(err_addr),
      .key_sel(key_sel), .key_up(key_up), .freq_set(freq_set), .rez1(rez1), .rez2(rez2),
      .rez3(rez3), .elapsed(elapsed), .freq(freq), .mark(mark), .bg(bg));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic put(input logic [5:0] in);
      vec_t v;
      v.in = in; v.chk = 1'b0; v.fs = '0; v.fq = '0; v.r1 = '0; v.r2 = '0;
      v.r3 = '0; v.bg = '0; v.mk = '0;
      tbl.push_back(v);
   endtask

   task automatic exp_row(input logic [5:0] in, input logic [15:0] fs, input logic [15:0] fq,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [1:0] r3,
                          input logic [5:0] bg_e, input logic [7:0] mk);
      vec_t v;
      v.in = in; v.chk = 1'b1; v.fs = fs; v.fq = fq; v.r1 = r1; v.r2 = r2;
      v.r3 = r3; v.bg = bg_e; v.mk = mk;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic [5:0] in);
      {vs_in, test_run, pass_strobe, err_strobe, key_sel, key_up} = in;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      vs_in = 1'b1;
      cyc(1);
      vs_in = 1'b0;
      cyc(1);
   endtask

   initial begin
      reset_n = 1'b0;
      err_addr = 32'hDEADBEEF;
      drive(NO);

      // IDLE frames
      for (int i = 0; i < 3; i++) begin
         put(VS);
         exp_row(NO, 16'h0100, 16'h0100, 0, 0, 0, 6'b000010, 8'h08);
      end
      // cursor to 2, then 12 increments of digit [7:4]
      put(KS); put(KS);
      for (int i = 0; i < 11; i++) put(KU);
      exp_row(KU, 16'h0120, 16'h0100, 0, 0, 0, 6'b000010, 8'h08);
      exp_row(VS, 16'h0120, 16'h0100, 0, 0, 0, 6'b000010, 8'h08);
      exp_row(NO, 16'h0120, 16'h0120, 0, 0, 0, 6'b000010, 8'h02);
      // RUN with 5 passes
      put(RN);
      for (int i = 0; i < 5; i++) put(RN | PS);
      put(RN | VS);
      exp_row(RN, 16'h0120, 16'h0120, 32'h5, 0, 2'd1, 6'b100000, 8'h00);
      // simultaneous pass+err -> ERR; keys ignored
      put(RN | PS | ES);
      put(RN | KS | KU);
      put(RN | VS);
      exp_row(RN, 16'h0120, 16'h0120, 32'h6, ERR1, 2'd2, 6'b001000, 8'h00);
      // back to IDLE, counters retained
      put(NO);
      put(VS);
      exp_row(NO, 16'h0120, 16'h0120, 32'h6, ERR1, 2'd0, 6'b000010, 8'h02);
      // sel+up together edits at old cursor; cursor wraps 3->0
      exp_row(KS | KU, 16'h0130, 16'h0120, 32'h6, ERR1, 2'd0, 6'b000010, 8'h02);
      put(KU); put(KS); put(KS);
      exp_row(KU, 16'h1140, 16'h0120, 32'h6, ERR1, 2'd0, 6'b000010, 8'h02);
      put(VS);
      exp_row(NO, 16'h1140, 16'h1140, 32'h6, ERR1, 2'd0, 6'b000010, 8'h08);

      // reset state, during and after reset
      cyc(2);
      chk("rst_rez1", rez1, 0);
      chk("rst_bg", {26'd0, bg}, 32'h02);
      reset_n = 1'b1;
      cyc(1);
      chk("rst_freq_set", {16'd0, freq_set}, 32'h0100);
      chk("rst_freq", {16'd0, freq}, 32'h0100);
      chk("rst_rez2", rez2, 0);
      chk("rst_rez3", {30'd0, rez3}, 0);
      chk("rst_elapsed", {16'd0, elapsed}, 0);
      chk("rst_mark", {24'd0, mark}, 0);

      // blink: mark on for snapshots 1..35, off 36..70, on again at 71
      for (int k = 1; k <= 71; k++) begin
         frame();
         if (k == 1 || k == 35 || k == 36 || k == 70 || k == 71)
            chk($sformatf("blink_mark_f%0d", k), {24'd0, mark},
                (k <= 35 || k == 71) ? 32'h08 : 32'h00);
      end

      foreach (tbl[i]) begin
         drive(tbl[i].in);
         cyc(1);
         if (tbl[i].chk) begin
            chk($sformatf("row%0d freq_set", i), {16'd0, freq_set}, {16'd0, tbl[i].fs});
            chk($sformatf("row%0d freq", i), {16'd0, freq}, {16'd0, tbl[i].fq});
            chk($sformatf("row%0d rez1", i), rez1, tbl[i].r1);
            chk($sformatf("row%0d rez2", i), rez2, tbl[i].r2);
            chk($sformatf("row%0d rez3", i), {30'd0, rez3}, {30'd0, tbl[i].r3});
            chk($sformatf("row%0d bg", i), {26'd0, bg}, {26'd0, tbl[i].bg});
            chk($sformatf("row%0d mark", i), {24'd0, mark}, {24'd0, tbl[i].mk});
         end
      end
      drive(NO);

      // elapsed: 960 counted RUN cycles at TICK_DIV=4 -> 240 s -> 04:00
      test_run = 1'b1;
      cyc(1);
      cyc(959);
      test_run = 1'b0;
      cyc(1);
      frame();
      chk("elapsed_0400", {16'd0, elapsed}, 32'h0400);
      chk("elapsed_rez1_cleared", rez1, 0);
      chk("elapsed_rez2", rez2, ERR0);
      chk("elapsed_rez3", {30'd0, rez3}, 0);

      // elapsed saturation at 99:59 forces status 3 even in IDLE
      test_run = 1'b1;
      cyc(24100);
      test_run = 1'b0;
      cyc(1);
      frame();
      chk("elapsed_sat", {16'd0, elapsed}, 32'h9959);
      chk("elapsed_sat_rez3", {30'd0, rez3}, 32'd3);

      // pass count saturation
      test_run = 1'b1;
      cyc(1);
      force dut.u_pass.cnt_q = 32'h99999998;
      cyc(1);
      release dut.u_pass.cnt_q;
      pass_strobe = 1'b1;
      cyc(2);
      pass_strobe = 1'b0;
      frame();
      chk("pass_sat_rez1", rez1, 32'h99999999);
      chk("pass_sat_rez3", {30'd0, rez3}, 32'd3);
      chk("pass_sat_bg", {26'd0, bg}, 32'h20);

      // asynchronous reset mid-RUN; strobes right after release are ignored
      reset_n = 1'b0;
      #1;
      chk("midrst_rez1", rez1, 0);
      chk("midrst_rez3", {30'd0, rez3}, 0);
      chk("midrst_bg", {26'd0, bg}, 32'h02);
      chk("midrst_freq", {16'd0, freq}, 32'h0100);
      @(negedge clk);
      reset_n = 1'b1;
      test_run = 1'b0;
      pass_strobe = 1'b1;
      err_strobe = 1'b1;
      cyc(1);
      pass_strobe = 1'b0;
      err_strobe = 1'b0;
      frame();
      chk("postrst_rez1", rez1, 0);
      chk("postrst_rez2", rez2, 0);
      chk("postrst_rez3", {30'd0, rez3}, 0);
      chk("postrst_mark", {24'd0, mark}, 32'h08);
      chk("postrst_freq_set", {16'd0, freq_set}, 32'h0100);

      // ERR blink from a fresh frame count
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      test_run = 1'b1;
      cyc(1);
      err_strobe = 1'b1;
      cyc(1);
      err_strobe = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         frame();
         chk($sformatf("err_bg_f%0d", k), {26'd0, bg}, (k <= 35) ? 32'h08 : 32'h00);
         if (k == 1) begin
            chk("err_rez3", {30'd0, rez3}, 32'd2);
            chk("err_rez2", rez2, ERR1);
            chk("err_mark", {24'd0, mark}, 0);
         end
      end
      test_run = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
